pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Collects stall requests from IF, ID, EX and MEM and produces the per-stage stall vector.
- Takes the taken-branch/jump decision and target from EX and turns it into a registered PC redirect plus a two-cycle wrong-path flush.
- Sits beside the pipeline registers. Drives pc_reg, if_id, id_ex, ex_mem and mem_wb.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_stall_enc.sv | 25 ++
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared stall bit indices, stall patterns and sequencer state encoding for pipe_ctrl.
package pipe_ctrl_pkg;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;
    localparam int STALL_BUS_W = 6;

    localparam logic [STALL_BUS_W-1:0] STALL_NONE   = 6'b000000;
    localparam logic [STALL_BUS_W-1:0] STALL_BY_IF  = 6'b000011;
    localparam logic [STALL_BUS_W-1:0] STALL_BY_ID  = 6'b000111;
    localparam logic [STALL_BUS_W-1:0] STALL_BY_EX  = 6'b001111;
    localparam logic [STALL_BUS_W-1:0] STALL_BY_MEM = 6'b011111;

    localparam logic BRANCH_ENABLE  = 1'b1;
    localparam logic BRANCH_DISABLE = 1'b0;

    typedef enum logic {
        CTRL_RUN   = 1'b0,
        CTRL_REDIR = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipe_stall_enc.sv
// Priority encoder: the oldest stalling stage decides how much of the pipe holds.
module pipe_stall_enc
    import pipe_ctrl_pkg::*;
(
    input  logic                   stallreq_if_i,
    input  logic                   stallreq_id_i,
    input  logic                   stallreq_ex_i,
    input  logic                   stallreq_mem_i,
    output logic [STALL_BUS_W-1:0] stall_o
);

    always_comb begin
        stall_o = STALL_NONE;
        if (stallreq_mem_i) begin
            stall_o = STALL_BY_MEM;
        end else if (stallreq_ex_i) begin
            stall_o = STALL_BY_EX;
        end else if (stallreq_id_i) begin
            stall_o = STALL_BY_ID;
        end else if (stallreq_if_i) begin
            stall_o = STALL_BY_IF;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall vector, branch flush and registered PC redirect.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if_i,
    input  logic              stallreq_id_i,
    input  logic              stallreq_ex_i,
    input  logic              stallreq_mem_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic [STALL_W-1:0] stall_o,
    output logic              flush_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cyc_o,
    output logic [31:0]       perf_flush_cnt_o
`endif
);

    logic [STALL_BUS_W-1:0] stall_enc;
    ctrl_state_e            state_q, state_d;
    logic [ADDR_W-1:0]      target_q, target_d;
    logic                   ex_adv;
    logic                   branch_accept;

    pipe_stall_enc u_stall_enc (
        .stallreq_if_i (stallreq_if_i),
        .stallreq_id_i (stallreq_id_i),
        .stallreq_ex_i (stallreq_ex_i),
        .stallreq_mem_i(stallreq_mem_i),
        .stall_o       (stall_enc)
    );

    // Outputs are forced quiet during reset so nothing downstream moves on that edge.
    generate
        for (genvar gi = 0; gi < STALL_W; gi++) begin : g_stall
            if (gi < STALL_BUS_W) begin : g_map
                assign stall_o[gi] = rst ? 1'b0 : stall_enc[gi];
            end else begin : g_pad
                assign stall_o[gi] = 1'b0;
            end
        end
    endgenerate

    assign ex_adv        = ~stall_o[STALL_EX];
    assign branch_accept = (state_q == CTRL_RUN) && (branch_flag_i == BRANCH_ENABLE) && ex_adv;

    always_comb begin
        state_d          = state_q;
        target_d         = target_q;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        busy_o           = 1'b0;
        unique case (state_q)
            CTRL_RUN: begin
                if (branch_accept) begin
                    flush_o  = 1'b1;
                    target_d = branch_addr_i;
                    state_d  = CTRL_REDIR;
                end
            end
            CTRL_REDIR: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = target_q;
                busy_o           = 1'b1;
                // pc_reg only takes the target on an edge where it is not held.
                if (!stall_o[STALL_PC]) begin
                    state_d = CTRL_RUN;
                end
            end
            default: state_d = CTRL_RUN;
        endcase
        if (rst) begin
            flush_o          = 1'b0;
            redirect_valid_o = 1'b0;
            redirect_pc_o    = '0;
            busy_o           = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CTRL_RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_o != '0) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (branch_accept) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cyc_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int ADDR_W  = 32;
    localparam int STALL_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_addr_i;
    logic [STALL_W-1:0] stall_o;
    logic              flush_o, redirect_valid_o, busy_o;
    logic [ADDR_W-1:0] redirect_pc_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]       perf_stall_cyc_o, perf_flush_cnt_o;
`endif

    pipe_ctrl #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_if_i   (stallreq_if_i),
        .stallreq_id_i   (stallreq_id_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .stallreq_mem_i  (stallreq_mem_i),
        .branch_flag_i   (branch_flag_i),
        .branch_addr_i   (branch_addr_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o   (redirect_pc_o),
        .busy_o          (busy_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cyc_o(perf_stall_cyc_o),
        .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: a redirect is "owed" after an accepted branch until the PC is free to take it.
    bit          m_owed;
    logic [31:0] m_target;
    logic [31:0] m_stall_cnt, m_flush_cnt;
    logic [5:0]  e_stall;
    bit          e_accept;

    function automatic logic [5:0] stall_model(bit r, bit fi, bit di, bit xi, bit mi);
        int depth;
        if (r) return 6'd0;
        depth = mi ? 5 : xi ? 4 : di ? 3 : fi ? 2 : 0;
        return 6'((1 << depth) - 1);
    endfunction

    task automatic drv(input bit r, input bit fi, input bit di, input bit xi, input bit mi,
                       input bit bf, input logic [31:0] ba);
        bit owed_vis;
        @(negedge clk);
        rst = r; stallreq_if_i = fi; stallreq_id_i = di; stallreq_ex_i = xi;
        stallreq_mem_i = mi; branch_flag_i = bf; branch_addr_i = ba;
        #2;
        e_stall  = stall_model(r, fi, di, xi, mi);
        owed_vis = !r && m_owed;
        e_accept = !r && !m_owed && bf && (e_stall < 6'b001111);
        chk("stall", 64'(stall_o), 64'(e_stall));
        chk("flush", 64'(flush_o), 64'(owed_vis || e_accept));
        chk("redir_valid", 64'(redirect_valid_o), 64'(owed_vis));
        chk("redir_pc", 64'(redirect_pc_o), owed_vis ? 64'(m_target) : 64'd0);
        chk("busy", 64'(busy_o), 64'(owed_vis));
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall", 64'(perf_stall_cyc_o), 64'(m_stall_cnt));
        chk("perf_flush", 64'(perf_flush_cnt_o), 64'(m_flush_cnt));
`endif
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            m_owed = 0; m_target = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (e_stall != 0) m_stall_cnt = m_stall_cnt + 1;
            if (m_owed) begin
                if (e_stall == 0) m_owed = 0;
            end else if (e_accept) begin
                m_owed = 1; m_target = branch_addr_i; m_flush_cnt = m_flush_cnt + 1;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit fi, input bit di, input bit xi, input bit mi,
                       input bit bf, input logic [31:0] ba);
        drv(r, fi, di, xi, mi, bf, ba);
        adv();
    endtask

    initial begin
        m_owed = 0; m_target = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        rst = 1; stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0;
        stallreq_mem_i = 0; branch_flag_i = 0; branch_addr_i = 0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Reset lands while a redirect to 0x80 is pending.
        cyc(0, 0, 0, 0, 0, 1, 32'h80);
        drv(0, 1, 0, 0, 0, 0, 0);
        chk("s1_redir_pc", 64'(redirect_pc_o), 64'h80);
        adv();
        cyc(1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("s1_no_redir", 64'(redirect_valid_o), 64'd0);
        chk("s1_busy", 64'(busy_o), 64'd0);
        adv();

        // Stall priority.
        drv(0, 0, 1, 0, 0, 0, 0);
        chk("s2_id", 64'(stall_o), 64'b000111);
        adv();
        drv(0, 0, 1, 0, 1, 0, 0);
        chk("s2_mem", 64'(stall_o), 64'b011111);
        adv();
        drv(0, 1, 0, 0, 0, 0, 0);
        chk("s2_if", 64'(stall_o), 64'b000011);
        adv();
        drv(0, 0, 0, 1, 0, 0, 0);
        chk("s2_ex", 64'(stall_o), 64'b001111);
        adv();

        // Plain taken branch to 0x104.
        drv(0, 0, 0, 0, 0, 1, 32'h104);
        chk("s3_flush_n", 64'(flush_o), 64'd1);
        chk("s3_novalid_n", 64'(redirect_valid_o), 64'd0);
        adv();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("s3_pc_n1", 64'(redirect_pc_o), 64'h104);
        adv();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("s3_busy_n2", 64'(busy_o), 64'd0);
        adv();

        // Branch held off by a mem stall, then accepted.
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 1, 1, 32'h104);
            chk("s4_noflush", 64'(flush_o), 64'd0);
            adv();
        end
        cyc(0, 0, 0, 0, 0, 1, 32'h104);

        // IF stall keeps the redirect pending; branch pulses ignored.
        drv(0, 1, 0, 0, 0, 1, 32'h200);
        chk("s5_pc0", 64'(redirect_pc_o), 64'h104);
        adv();
        drv(0, 1, 0, 0, 0, 1, 32'h300);
        chk("s5_pc1", 64'(redirect_pc_o), 64'h104);
        adv();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("s5_pc2", 64'(redirect_pc_o), 64'h104);
        chk("s5_flush2", 64'(flush_o), 64'd1);
        adv();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("s5_done", 64'(busy_o), 64'd0);
        adv();

        // Accepted branch while younger stages request stalls still flushes.
        drv(0, 1, 1, 0, 0, 1, 32'h400);
        chk("accept_id_stall", 64'(flush_o), 64'd1);
        adv();

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                ($urandom_range(5) == 0), ($urandom_range(5) == 0), ($urandom_range(2) == 0),
                $urandom() & 32'hFFFF_FFFE);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
